// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - oversampled UART transmitter with holding register, parity, stop length and break
module uart_tx_param #(
    parameter int NUM_TICKS     = 16,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [MAX_DATA_BITS-1:0] s_data,
    input  logic [1:0]               data_bits,
    input  logic [1:0]               parity_mode,
    input  logic [1:0]               stop_bits,
    input  logic                     send_break,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     tx_done
);

    // Tick counter must reach 2*NUM_TICKS-1 for a two-bit stop.
    localparam int SW = $clog2(2 * NUM_TICKS);
    localparam int NW = $clog2(MAX_DATA_BITS + 1);

    localparam logic [SW-1:0] BIT_LAST    = SW'(NUM_TICKS - 1);
    localparam logic [SW-1:0] STOP15_LAST = SW'((3 * NUM_TICKS) / 2 - 1);
    localparam logic [SW-1:0] STOP2_LAST  = SW'(2 * NUM_TICKS - 1);

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_BREAK  = 6'b100000
    } state_t;

    state_t                   state_q, state_d;
    logic [SW-1:0]            s_q, s_d;
    logic [NW-1:0]            n_q, n_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic [MAX_DATA_BITS-1:0] hold_q, hold_d;
    logic                     hold_full_q, hold_full_d;
    logic                     s_ready_q;
    logic                     tx_q, tx_d;
    logic                     done_q, done_d;
    logic [NW-1:0]            nbits_q, nbits_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic [1:0]               stop_q, stop_d;
    logic                     brk_q, brk_d;

    logic [NW-1:0]            nbits_in;
    logic                     par_x;
    logic                     par_in;
    logic [SW-1:0]            stop_last;
    logic                     load;
    logic                     take;

    // Requested data length 5..8, clamped to the width of s_data.
    assign nbits_in = ((32'd5 + 32'(data_bits)) > 32'(MAX_DATA_BITS))
                    ? NW'(MAX_DATA_BITS) : NW'(32'd5 + 32'(data_bits));

    assign load    = s_valid && s_ready_q;
    assign s_ready = s_ready_q;
    assign tx_out  = tx_q;
    assign tx_done = done_q;
    assign busy    = (state_q != ST_IDLE);

    // Parity of the held byte over the selected data bits only.
    always_comb begin
        par_x = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < int'(nbits_in)) begin
                par_x = par_x ^ hold_q[i];
            end
        end
        case (parity_mode)
            2'b01:   par_in = par_x;
            2'b10:   par_in = ~par_x;
            default: par_in = 1'b1;
        endcase
    end

    // Last tick index of the stop period for the latched stop length.
    always_comb begin
        case (stop_q)
            2'b00:   stop_last = BIT_LAST;
            2'b01:   stop_last = STOP15_LAST;
            default: stop_last = STOP2_LAST;
        endcase
    end

    // Next-state, holding register and registered line level.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        nbits_d     = nbits_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop_d      = stop_q;
        brk_d       = brk_q;
        done_d      = 1'b0;
        take        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (send_break) begin
                    state_d = ST_BREAK;
                    stop_d  = stop_bits;
                    brk_d   = 1'b1;
                end else if (hold_full_q) begin
                    take = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == nbits_q - NW'(1)) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == stop_last) begin
                        s_d    = '0;
                        done_d = !brk_q;
                        // Uses the registered flag, so a byte loaded on this edge waits for IDLE.
                        if (hold_full_q) begin
                            take = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_BREAK: begin
                if (!send_break) begin
                    state_d = ST_STOP;
                    s_d     = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase

        if (take) begin
            state_d     = ST_START;
            shift_d     = hold_q;
            nbits_d     = nbits_in;
            par_en_d    = (parity_mode != 2'b00);
            par_bit_d   = par_in;
            stop_d      = stop_bits;
            brk_d       = 1'b0;
            s_d         = '0;
            n_d         = '0;
            hold_full_d = 1'b0;
        end

        if (load) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            ST_BREAK:  tx_d = 1'b0;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            s_ready_q   <= 1'b1;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
            nbits_q     <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_q      <= 2'b00;
            brk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            s_ready_q   <= !hold_full_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
            nbits_q     <= nbits_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            stop_q      <= stop_d;
            brk_q       <= brk_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param against a frame-level model
module tb_uart_tx_param;

    localparam int NT = 16;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [1:0] data_bits;
    logic [1:0] parity_mode;
    logic [1:0] stop_bits;
    logic       send_break;
    logic       tx_out;
    logic       busy;
    logic       tx_done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int d0;

    uart_tx_param #(.NUM_TICKS(NT), .MAX_DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .send_break  (send_break),
        .tx_out      (tx_out),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every third clock, changed away from the rising edge.
    initial begin
        int tc;
        tc   = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tc   = tc + 1;
            tick = (tc % 3 == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a level list: start, data LSB first, optional parity; stop handled as length.
    function automatic void build(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm,
                                  input logic [1:0] sb, output logic [11:0] lv, output int nb,
                                  output int st);
        int   nd;
        logic p;
        nd = 5 + int'(db);
        lv = '0;
        p  = 1'b0;
        for (int i = 0; i < nd; i++) begin
            lv[1 + i] = d[i];
            p = p ^ d[i];
        end
        nb = 1 + nd;
        if (pm != 2'b00) begin
            lv[nb] = (pm == 2'b01) ? p : ((pm == 2'b10) ? ~p : 1'b1);
            nb = nb + 1;
        end
        st = stop_ticks(sb);
    endfunction

    function automatic int stop_ticks(input logic [1:0] sb);
        return (sb == 2'b00) ? NT : ((sb == 2'b01) ? (3 * NT) / 2 : 2 * NT);
    endfunction

    // Model state: mode 0 idle, 1 sending segments, 2 break.
    logic [11:0] m_lv;
    int          m_nb, m_st, m_k, m_cnt, m_mode;
    logic        m_nodone, m_hold_full, m_tx, m_ready, m_done, m_ld;
    logic [7:0]  m_hold;

    task automatic m_start();
        build(m_hold, data_bits, parity_mode, stop_bits, m_lv, m_nb, m_st);
        m_hold_full = 1'b0;
        m_mode      = 1;
        m_k         = 0;
        m_cnt       = 0;
        m_nodone    = 1'b0;
        m_tx        = 1'b0;
    endtask

    // Reference model advanced on every clock.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_hold_full = 1'b0; m_tx = 1'b1; m_ready = 1'b1; m_done = 1'b0;
            m_k = 0; m_cnt = 0; m_nb = 0; m_st = NT; m_nodone = 1'b0;
        end else begin
            m_ld   = s_valid && m_ready;
            m_done = 1'b0;
            if (m_mode == 0) begin
                if (send_break) begin
                    m_mode = 2;
                    m_st   = stop_ticks(stop_bits);
                    m_tx   = 1'b0;
                end else if (m_hold_full) begin
                    m_start();
                end
            end else if (m_mode == 2) begin
                if (!send_break) begin
                    m_mode = 1; m_nb = 0; m_k = 0; m_cnt = 0; m_nodone = 1'b1; m_tx = 1'b1;
                end
            end else if (tick) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == ((m_k < m_nb) ? NT : m_st)) begin
                    m_cnt = 0;
                    m_k   = m_k + 1;
                    if (m_k > m_nb) begin
                        m_done = !m_nodone;
                        if (m_hold_full) m_start();
                        else begin
                            m_mode = 0;
                            m_tx   = 1'b1;
                        end
                    end else begin
                        m_tx = (m_k < m_nb) ? m_lv[m_k] : 1'b1;
                    end
                end
            end
            if (m_ld) begin
                m_hold      = s_data;
                m_hold_full = 1'b1;
            end
            m_ready = !m_hold_full;
        end
    end

    // Cycle compare of every output against the model.
    always @(negedge clk) begin
        chk("tx_out", tx_out, m_tx);
        chk("s_ready", s_ready, m_ready);
        chk("busy", busy, (m_mode != 0));
        chk("tx_done", tx_done, m_done);
    end

    always @(posedge clk) begin
        if (tx_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic cfg(input logic [1:0] db, input logic [1:0] pm, input logic [1:0] sb);
        @(negedge clk);
        data_bits   = db;
        parity_mode = pm;
        stop_bits   = sb;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int i;
        for (i = 0; i < 4000 && s_ready !== 1'b1; i++) @(negedge clk);
        chk("send_timeout", (i < 4000), 1);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && s_ready === 1'b1) break;
        end
        chk("idle_timeout", (i < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clk);
            if (tick) c = c + 1;
        end
    endtask

    logic [11:0] p_lv;
    int          p_nb, p_st;

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; send_break = 1'b0;
        data_bits = 2'b11; parity_mode = 2'b00; stop_bits = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_out, 1); chk("rst_ready", s_ready, 1);
        chk("rst_busy", busy, 0); chk("rst_done", tx_done, 0);
        reset = 1'b0;

        build(8'hA5, 2'b11, 2'b00, 2'b00, p_lv, p_nb, p_st);
        chk("pin_a5_lv", p_lv, 12'h14A); chk("pin_a5_nb", p_nb, 9); chk("pin_a5_st", p_st, 16);
        build(8'h03, 2'b10, 2'b01, 2'b10, p_lv, p_nb, p_st);
        chk("pin_03_lv", p_lv, 12'h006); chk("pin_03_st", p_st, 32);
        build(8'h7F, 2'b10, 2'b01, 2'b10, p_lv, p_nb, p_st);
        chk("pin_7f_lv", p_lv, 12'h1FE); chk("pin_7f_nb", p_nb, 9);
        build(8'h1F, 2'b00, 2'b10, 2'b01, p_lv, p_nb, p_st);
        chk("pin_1f_lv", p_lv, 12'h03E); chk("pin_1f_nb", p_nb, 7); chk("pin_1f_st", p_st, 24);
        build(8'hFF, 2'b00, 2'b10, 2'b01, p_lv, p_nb, p_st);
        chk("pin_ff_lv", p_lv, 12'h03E);
        build(8'h00, 2'b11, 2'b11, 2'b00, p_lv, p_nb, p_st);
        chk("pin_mark_lv", p_lv, 12'h200); chk("pin_mark_nb", p_nb, 10);

        // 8N1 single frame
        cfg(2'b11, 2'b00, 2'b00);
        d0 = done_cnt;
        send_byte(8'hA5);
        wait_idle();
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_busy", busy, 0);

        // 7E2 two frames
        cfg(2'b10, 2'b01, 2'b10);
        d0 = done_cnt;
        send_byte(8'h03);
        send_byte(8'h7F);
        wait_idle();
        chk("t2_done", done_cnt - d0, 2);

        // back-to-back 8N1
        cfg(2'b11, 2'b00, 2'b00);
        d0 = done_cnt;
        send_byte(8'h55);
        send_byte(8'hAA);
        wait_idle();
        chk("t3_done", done_cnt - d0, 2);

        // 5O1.5 with a config change mid-frame, then upper bits set
        cfg(2'b00, 2'b10, 2'b01);
        d0 = done_cnt;
        send_byte(8'h1F);
        wait_ticks(20);
        cfg(2'b11, 2'b00, 2'b00);
        wait_idle();
        cfg(2'b00, 2'b10, 2'b01);
        send_byte(8'hFF);
        wait_idle();
        chk("t4_done", done_cnt - d0, 2);

        // break with a byte pending
        cfg(2'b11, 2'b00, 2'b00);
        d0 = done_cnt;
        @(negedge clk);
        send_break = 1'b1;
        s_valid    = 1'b1;
        s_data     = 8'h3C;
        @(negedge clk);
        s_valid = 1'b0;
        wait_ticks(50);
        @(negedge clk);
        chk("t5_brk_tx", tx_out, 0);
        chk("t5_brk_busy", busy, 1);
        send_break = 1'b0;
        wait_idle();
        chk("t5_done", done_cnt - d0, 1);

        // reset during data bit 3
        d0 = done_cnt;
        send_byte(8'h96);
        wait_ticks(72);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_tx", tx_out, 1); chk("t6_ready", s_ready, 1);
        chk("t6_busy", busy, 0); chk("t6_txdone", tx_done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_nodone", done_cnt - d0, 0);
        send_byte(8'h3C);
        wait_idle();
        chk("t6_done", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised, oversampled UART transmitter with a valid/ready byte input and a one-entry holding register, so frames can be sent back-to-back.
Data width, parity mode and stop length are selected at run time and captured per frame.
Adds even/odd/mark parity, 1/1.5/2 stop bits and line-break generation.
Sits between the baud-tick generator and the TX pin, fed by the host-side interface logic.

Parameters:
NUM_TICKS, 16, tick pulses per bit period; must be even and >= 4.
MAX_DATA_BITS, 8, width of s_data; also the upper limit on data bits per frame.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  single-cycle oversampling strobe from the baud generator
s_valid  in  1  input byte valid
s_ready  out  1  holding register empty; a transfer occurs when s_valid && s_ready
s_data  in  MAX_DATA_BITS  byte to send, LSB first
data_bits  in  2  data bits per frame: 00=5, 01=6, 10=7, 11=8 (values above MAX_DATA_BITS are clamped to it)
parity_mode  in  2  00=none, 01=even, 10=odd, 11=mark (always 1)
stop_bits  in  2  stop length: 00=1 bit, 01=1.5 bits, 10 or 11=2 bits
send_break  in  1  force the line low (break)
tx_out  out  1  serial line, registered, idles high
busy  out  1  high in any state other than IDLE
tx_done  out  1  one-cycle pulse at the end of each data frame

Behaviour:
- Reset (asynchronous): takes effect immediately, even mid-frame.
  - Outputs: tx_out=1, s_ready=1, busy=0, tx_done=0.
  - State: IDLE; holding register emptied; tick counter and bit counter cleared.
  - No tx_done is generated for an aborted frame.
- Holding register:
  - Loads s_data on clk when s_valid && s_ready.
  - s_ready is registered and equals !hold_full; it drops the cycle after a load.
  - Emptied when its contents move to the shift register. s_ready is asserted the following cycle.
- Frame capture: on entry to START, the shift register, data_bits, parity_mode and stop_bits are all latched. Input changes mid-frame have no effect.
- Parity is computed over the selected data bits only.
  - even: XOR of the data bits; odd: the inverse of that; mark: 1.
  - Unused upper bits of s_data are ignored.
- Tick counting: counter s advances only on clk edges where tick=1. Each bit lasts NUM_TICKS ticks, with tx_out held constant for the whole bit.
- State machine (one-hot):
  - IDLE -> BREAK if send_break=1. Break has priority over a pending byte.
  - IDLE -> START if hold_full, otherwise stay in IDLE.
    - The transition happens on the next clk edge, without waiting for a tick.
    - tx_out=0 is registered on that same edge.
  - START: after NUM_TICKS ticks -> DATA with bit index n=0.
  - DATA: tx_out = shift[0]. After NUM_TICKS ticks, shift right and increment n.
    - When n reaches (data bits - 1), go to PARITY if parity_mode != 00, else to STOP.
  - PARITY: tx_out = parity bit for NUM_TICKS ticks -> STOP.
  - STOP: tx_out=1. Duration: NUM_TICKS ticks (1 bit), 3*NUM_TICKS/2 (1.5 bits) or 2*NUM_TICKS (2 bits).
    - On the last tick, tx_done pulses for one clk.
    - Next state is START (back-to-back, no idle gap) if hold_full, otherwise IDLE.
  - BREAK: tx_out=0 while send_break=1.
    - When send_break falls -> STOP with the latched stop length.
    - tx_done is not pulsed at the end of a break.
- Simultaneous events:
  - A load into the holding register during STOP's last cycle does not count for the back-to-back decision. The byte starts from IDLE one clk later.
  - send_break raised mid-frame is ignored until IDLE.
- An illegal state encoding returns to IDLE with tx_out=1.

Test Plan:
1. 8N1, NUM_TICKS=16, s_data=8'hA5 → tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 ticks; one tx_done pulse; busy low afterwards.
2. 7E2, s_data=8'h03, then 8'h7F → bits 1,1,0,0,0,0,0 with parity 0 then 2 stop bits (32 ticks); second frame parity 1 (odd count of seven 1s ⇒ even parity bit 1).
3. Back-to-back: load 8'h55 then 8'hAA while the first frame is sending → second start bit immediately follows the final stop tick; s_ready high again after the second load into shift; two tx_done pulses.
4. 5O1.5, s_data=8'h1F → five 1s, odd parity bit 0, stop lasting 24 ticks; bits 7:5 of s_data ignored.
5. send_break held high for 50 ticks from IDLE with a byte pending → tx_out=0 for 50 ticks, then 1-bit stop, no tx_done, then the pending byte is transmitted.
6. Assert reset during DATA bit 3 → tx_out=1 immediately, s_ready=1, busy=0, no tx_done; next loaded byte is sent as a complete, correct frame.
